// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port word memory between the IF fetch port and the MEM load/store port.
// Optional macro ARB_RR_EN: alternate grants under contention instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int unsigned AW        = 30,
  parameter int unsigned DW        = 32,
  parameter int unsigned TO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          err
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_d;
  logic          m_req_d, m_we_d, i_ack_d, d_ack_d, err_d;
  logic          cancel, cancel_d;
  logic [AW-1:0] m_addr_d;
  logic [DW-1:0] m_wdata_d, i_rdata_d, d_rdata_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          i_elig, d_elig, grant_i, grant_d, timeout;

  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

  // A port is not eligible in the cycle its own ack is being returned.
  assign i_elig  = i_req & ~i_ack & ~i_flush;
  assign d_elig  = d_req & ~d_ack;
  assign timeout = (cnt == CW'(TO_CYCLES - 1));

`ifdef ARB_RR_EN
  logic last_grant, last_grant_d;  // 1 = D port granted last
  assign grant_d = d_elig & (~i_elig | ~last_grant);
`else
  assign grant_d = d_elig;
`endif
  assign grant_i = i_elig & ~grant_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state;
    m_req_d   = m_req;
    m_we_d    = m_we;
    m_addr_d  = m_addr;
    m_wdata_d = m_wdata;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    err_d     = err;
    cnt_d     = cnt;
    cancel_d  = cancel;
`ifdef ARB_RR_EN
    last_grant_d = last_grant;
`endif
    case (state)
      IDLE: begin
        cancel_d = 1'b0;
        if (grant_d) begin
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          cnt_d     = '0;
          state_d   = BUSY_D;
`ifdef ARB_RR_EN
          last_grant_d = 1'b1;
`endif
        end else if (grant_i) begin
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = i_addr;
          cnt_d    = '0;
          state_d  = BUSY_I;
`ifdef ARB_RR_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      BUSY_I: begin
        cancel_d = cancel | i_flush;
        if (m_ack || timeout) begin
          m_req_d  = 1'b0;
          cancel_d = 1'b0;
          state_d  = IDLE;
          if (!m_ack) err_d = 1'b1;
          // A flushed fetch still completes on the bus but is not delivered.
          if (!(cancel || i_flush)) begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_ack ? m_rdata : '0;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          d_ack_d = 1'b1;
          state_d = IDLE;
          if (!m_we) d_rdata_d = m_rdata;
        end else if (timeout) begin
          m_req_d   = 1'b0;
          d_ack_d   = 1'b1;
          d_rdata_d = '0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      cancel  <= 1'b0;
`ifdef ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      m_req   <= m_req_d;
      m_we    <= m_we_d;
      m_addr  <= m_addr_d;
      m_wdata <= m_wdata_d;
      i_ack   <= i_ack_d;
      d_ack   <= d_ack_d;
      i_rdata <= i_rdata_d;
      d_rdata <= d_rdata_d;
      err     <= err_d;
      cnt     <= cnt_d;
      cancel  <= cancel_d;
`ifdef ARB_RR_EN
      last_grant <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory that acks after mem_lat m_req cycles.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_flush, i_ack, i_stall;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ack, d_stall;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          m_req, m_we, m_ack, err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_i[$];
  logic [DW-1:0] exp_d[$];

  mem_port_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ack(i_ack),
    .i_rdata(i_rdata), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  always #5 clk = ~clk;

  // Memory contents: fixed pattern per address unless overwritten by a store.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (a == 30'h0000C00) ? 32'h8C010004 : (32'hA500_0000 | 32'(a[15:0]));
  endfunction

  logic [DW-1:0] mem [256];
  bit            wr_flag [256];
  int unsigned   mem_lat;
  int unsigned   req_cnt;
  logic          force_ack;

  assign m_ack   = force_ack | (m_req && mem_lat != 0 && req_cnt == mem_lat - 1);
  assign m_rdata = !m_ack ? 32'hBAD0_BAD0 :
                   wr_flag[m_addr[7:0]] ? mem[m_addr[7:0]] : pat(m_addr);

  always @(posedge clk) begin
    if (m_req && m_ack && m_we) begin
      mem[m_addr[7:0]]     <= m_wdata;
      wr_flag[m_addr[7:0]] <= 1'b1;
    end
    req_cnt <= (m_req && !m_ack) ? req_cnt + 1 : 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++;
    if ({m_req, m_we, i_ack, d_ack, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=00000", {m_req, m_we, i_ack, d_ack, err});
    end
    checks++;
    if (m_addr !== '0 || m_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      errors++; $display("FAIL reset_data m_addr=%h m_wdata=%h i_rdata=%h d_rdata=%h want all 0",
                         m_addr, m_wdata, i_rdata, d_rdata);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_fetch();
    logic [DW-1:0] e;
    mem_lat = 1; i_req = 1'b1; i_addr = 30'h0000C00;
    exp_i.push_back(32'h8C010004);
    step();
    checks++;
    if (!(m_req === 1'b1 && m_we === 1'b0 && m_addr === 30'h0000C00 && i_ack === 1'b0 && i_stall === 1'b1)) begin
      errors++; $display("FAIL fetch_req m_req=%b m_we=%b m_addr=%h i_ack=%b i_stall=%b want 1 0 0000c00 0 1",
                         m_req, m_we, m_addr, i_ack, i_stall);
    end
    step();
    checks++;
    if (!(m_req === 1'b0 && i_ack === 1'b1 && i_stall === 1'b0)) begin
      errors++; $display("FAIL fetch_ack m_req=%b i_ack=%b i_stall=%b want 0 1 0", m_req, i_ack, i_stall);
    end
    if (i_ack === 1'b1) begin
      e = exp_i.pop_front(); checks++;
      if (i_rdata !== e) begin errors++; $display("FAIL fetch_data got=%h want=%h", i_rdata, e); end
    end
    i_req = 1'b0;
    step();
    checks++;
    if (i_ack !== 1'b0) begin errors++; $display("FAIL fetch_pulse i_ack=%b want 0", i_ack); end
  endtask

  task automatic test_contention();
    logic [DW-1:0] e;
    logic [AW-1:0] first_addr, second_addr;
    bit            first_d;
    mem_lat = 1;
    i_req = 1'b1; i_addr = 30'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h10;
    exp_d.push_back(pat(30'h10)); exp_i.push_back(pat(30'h40));
    step();
    checks++;
    if (!(m_req === 1'b1 && m_addr === 30'h10 && m_we === 1'b0)) begin
      errors++; $display("FAIL cont1_first m_req=%b m_addr=%h want 1 10", m_req, m_addr);
    end
    step();
    checks++;
    if (d_ack !== 1'b1) begin errors++; $display("FAIL cont1_dack d_ack=%b want 1", d_ack); end
    if (d_ack === 1'b1) begin
      e = exp_d.pop_front(); checks++;
      if (d_rdata !== e) begin errors++; $display("FAIL cont1_ddata got=%h want=%h", d_rdata, e); end
    end
    d_req = 1'b0;
    step();
    checks++;
    if (!(m_req === 1'b1 && m_addr === 30'h40)) begin
      errors++; $display("FAIL cont1_second m_req=%b m_addr=%h want 1 40", m_req, m_addr);
    end
    step();
    checks++;
    if (i_ack !== 1'b1) begin errors++; $display("FAIL cont1_iack i_ack=%b want 1", i_ack); end
    if (i_ack === 1'b1) begin
      e = exp_i.pop_front(); checks++;
      if (i_rdata !== e) begin errors++; $display("FAIL cont1_idata got=%h want=%h", i_rdata, e); end
    end
    i_req = 1'b0;
    step();
    // Lone load makes D the last grant; the next contention shows the policy.
    d_req = 1'b1; d_addr = 30'h14; exp_d.push_back(pat(30'h14));
    step(); step();
    checks++;
    if (d_ack !== 1'b1) begin errors++; $display("FAIL lone_dack d_ack=%b want 1", d_ack); end
    if (d_ack === 1'b1) begin
      e = exp_d.pop_front(); checks++;
      if (d_rdata !== e) begin errors++; $display("FAIL lone_ddata got=%h want=%h", d_rdata, e); end
    end
    d_req = 1'b0;
    step();
    first_d     = !RR;
    first_addr  = first_d ? 30'h18 : 30'h48;
    second_addr = first_d ? 30'h48 : 30'h18;
    i_req = 1'b1; i_addr = 30'h48; d_req = 1'b1; d_addr = 30'h18;
    exp_d.push_back(pat(30'h18)); exp_i.push_back(pat(30'h48));
    for (int r = 0; r < 2; r++) begin
      step();
      checks++;
      if (!(m_req === 1'b1 && m_addr === (r == 0 ? first_addr : second_addr))) begin
        errors++; $display("FAIL cont2_grant%0d m_req=%b m_addr=%h want 1 %h", r, m_req, m_addr,
                           (r == 0 ? first_addr : second_addr));
      end
      step();
      checks++;
      if ({d_ack, i_ack} !== (((r == 0) == first_d) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL cont2_ack%0d d_ack=%b i_ack=%b", r, d_ack, i_ack);
      end
      if (d_ack === 1'b1) begin
        e = exp_d.pop_front(); checks++;
        if (d_rdata !== e) begin errors++; $display("FAIL cont2_ddata got=%h want=%h", d_rdata, e); end
        d_req = 1'b0;
      end
      if (i_ack === 1'b1) begin
        e = exp_i.pop_front(); checks++;
        if (i_rdata !== e) begin errors++; $display("FAIL cont2_idata got=%h want=%h", i_rdata, e); end
        i_req = 1'b0;
      end
    end
    d_req = 1'b0; i_req = 1'b0;
    step();
  endtask

  task automatic test_store();
    logic [DW-1:0] e;
    mem_lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'h20; d_wdata = 32'hDEADBEEF;
    exp_d.push_back(pat(30'h18));
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (!(m_req === 1'b1 && m_we === 1'b1 && m_addr === 30'h20 && m_wdata === 32'hDEADBEEF &&
            d_ack === 1'b0 && d_stall === 1'b1)) begin
        errors++; $display("FAIL store_hold%0d m_req=%b m_we=%b m_addr=%h m_wdata=%h d_ack=%b want 1 1 20 deadbeef 0",
                           k, m_req, m_we, m_addr, m_wdata, d_ack);
      end
    end
    step();
    checks++;
    if (!(d_ack === 1'b1 && m_req === 1'b0 && d_stall === 1'b0)) begin
      errors++; $display("FAIL store_ack d_ack=%b m_req=%b d_stall=%b want 1 0 0", d_ack, m_req, d_stall);
    end
    if (d_ack === 1'b1) begin
      e = exp_d.pop_front(); checks++;
      if (d_rdata !== e) begin errors++; $display("FAIL store_rdata got=%h want=%h", d_rdata, e); end
    end
    d_req = 1'b0; d_we = 1'b0;
    step();
    mem_lat = 1; d_req = 1'b1; d_addr = 30'h20; exp_d.push_back(32'hDEADBEEF);
    step(); step();
    checks++;
    if (d_ack !== 1'b1) begin errors++; $display("FAIL readback_ack d_ack=%b want 1", d_ack); end
    if (d_ack === 1'b1) begin
      e = exp_d.pop_front(); checks++;
      if (d_rdata !== e) begin errors++; $display("FAIL readback_data got=%h want=%h", d_rdata, e); end
    end
    d_req = 1'b0;
    step();
  endtask

  task automatic test_flush();
    bit seen_ack = 1'b0;
    bit data_bad = 1'b0;
    mem_lat = 3; i_req = 1'b1; i_addr = 30'h50;
    step(); step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0; i_req = 1'b0;
    checks++;
    if (m_req !== 1'b1) begin errors++; $display("FAIL flush_busy m_req=%b want 1", m_req); end
    step();
    checks++;
    if (m_req !== 1'b0) begin errors++; $display("FAIL flush_complete m_req=%b want 0", m_req); end
    for (int k = 0; k < 4; k++) begin
      if (i_ack !== 1'b0) seen_ack = 1'b1;
      if (i_rdata !== pat(30'h48)) data_bad = 1'b1;
      step();
    end
    checks++;
    if (seen_ack) begin errors++; $display("FAIL flush_noack i_ack seen=1 want 0"); end
    checks++;
    if (data_bad) begin errors++; $display("FAIL flush_rdata got=%h want=%h", i_rdata, pat(30'h48)); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    mem_lat = 1; i_req = 1'b1; i_addr = 30'h60;
    exp_i.push_back(pat(30'h60)); exp_i.push_back(pat(30'h64));
    for (int t = 0; t < 2; t++) begin
      step();
      checks++;
      if (!(m_req === 1'b1 && m_addr === (t == 0 ? 30'h60 : 30'h64))) begin
        errors++; $display("FAIL b2b_req%0d m_req=%b m_addr=%h", t, m_req, m_addr);
      end
      step();
      checks++;
      if (i_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d i_ack=%b want 1", t, i_ack); end
      if (i_ack === 1'b1) begin
        e = exp_i.pop_front(); checks++;
        if (i_rdata !== e) begin errors++; $display("FAIL b2b_data%0d got=%h want=%h", t, i_rdata, e); end
      end
      i_addr = 30'h64;
      if (t == 0) begin
        step();
        checks++;
        if (m_req !== 1'b0) begin errors++; $display("FAIL b2b_gap m_req=%b want 0", m_req); end
      end
    end
    i_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    logic [DW-1:0] e;
    mem_lat = 0; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h30;
    exp_d.push_back('0);
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (!(m_req === 1'b1 && d_ack === 1'b0 && err === 1'b0)) begin
        errors++; $display("FAIL to_wait%0d m_req=%b d_ack=%b err=%b want 1 0 0", k, m_req, d_ack, err);
      end
    end
    step();
    checks++;
    if (!(m_req === 1'b0 && d_ack === 1'b1 && err === 1'b1)) begin
      errors++; $display("FAIL to_abort m_req=%b d_ack=%b err=%b want 0 1 1", m_req, d_ack, err);
    end
    if (d_ack === 1'b1) begin
      e = exp_d.pop_front(); checks++;
      if (d_rdata !== e) begin errors++; $display("FAIL to_rdata got=%h want=%h", d_rdata, e); end
    end
    d_req = 1'b0;
    step();
    mem_lat = 1; i_req = 1'b1; i_addr = 30'h70; exp_i.push_back(pat(30'h70));
    step(); step();
    checks++;
    if (!(i_ack === 1'b1 && err === 1'b1)) begin
      errors++; $display("FAIL to_sticky i_ack=%b err=%b want 1 1", i_ack, err);
    end
    if (i_ack === 1'b1) begin
      e = exp_i.pop_front(); checks++;
      if (i_rdata !== e) begin errors++; $display("FAIL to_after_data got=%h want=%h", i_rdata, e); end
    end
    i_req = 1'b0;
    step();
  endtask

  task automatic test_reset_midop();
    mem_lat = 0; d_req = 1'b1; d_we = 1'b0; d_addr = 30'h34;
    step(); step();
    checks++;
    if (m_req !== 1'b1) begin errors++; $display("FAIL rmid_busy m_req=%b want 1", m_req); end
    rst = 1'b0; d_req = 1'b0;
    step();
    checks++;
    if ({m_req, m_we, d_ack, i_ack, err} !== 5'b0 || m_addr !== '0 || d_rdata !== '0 || i_rdata !== '0) begin
      errors++; $display("FAIL rmid_clear ctrl=%b m_addr=%h d_rdata=%h i_rdata=%h want all 0",
                         {m_req, m_we, d_ack, i_ack, err}, m_addr, d_rdata, i_rdata);
    end
    rst = 1'b1;
    step(); step();
    checks++;
    if (d_ack !== 1'b0 || m_req !== 1'b0) begin
      errors++; $display("FAIL rmid_noack d_ack=%b m_req=%b want 0 0", d_ack, m_req);
    end
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    step();
    checks++;
    if ({i_ack, d_ack, m_req} !== 3'b000) begin
      errors++; $display("FAIL stray_ack i_ack=%b d_ack=%b m_req=%b want 000", i_ack, d_ack, m_req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_lat = 1; force_ack = 1'b0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_flush();
    test_back_to_back();
    test_timeout();
    test_reset_midop();
    checks++;
    if (exp_i.size() != 0 || exp_d.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain pending_i=%0d pending_d=%0d want 0 0", exp_i.size(), exp_d.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
